// File: rtl/fetch_buffer_if.sv
// Fetch/decode side signal bundle for the fetch_buffer instruction queue.
// The slave modport is the queue itself; the master modport is fetch plus decode.
interface fetch_buffer_if #(
    parameter int DEPTH = 8
);
    logic                     flush_i;
    logic                     push_0_i;
    logic                     push_1_i;
    logic [31:0]              inst_0_i;
    logic [31:0]              inst_1_i;
    logic [31:0]              pc_0_i;
    logic [31:0]              pc_1_i;
    logic                     pred_taken_0_i;
    logic                     pred_taken_1_i;
    logic                     fetch_ready_o;
    logic [1:0]               take_i;
    logic                     valid_0_o;
    logic                     valid_1_o;
    logic [31:0]              inst_0_o;
    logic [31:0]              inst_1_o;
    logic [31:0]              pc_0_o;
    logic [31:0]              pc_1_o;
    logic                     pred_taken_0_o;
    logic                     pred_taken_1_o;
    logic [$clog2(DEPTH):0]   count_o;

    // Push side is a level handshake: a slot is written on any rising edge where
    // fetch_ready_o is high and push_0_i is high (push_1_i only alongside it).
    // Decode consumes take_i entries, clamped to what valid_0_o/valid_1_o show.
    modport master (
        output flush_i, push_0_i, push_1_i, inst_0_i, inst_1_i, pc_0_i, pc_1_i,
               pred_taken_0_i, pred_taken_1_i, take_i,
        input  fetch_ready_o, valid_0_o, valid_1_o, inst_0_o, inst_1_o, pc_0_o,
               pc_1_o, pred_taken_0_o, pred_taken_1_o, count_o
    );

    modport slave (
        input  flush_i, push_0_i, push_1_i, inst_0_i, inst_1_i, pc_0_i, pc_1_i,
               pred_taken_0_i, pred_taken_1_i, take_i,
        output fetch_ready_o, valid_0_o, valid_1_o, inst_0_o, inst_1_o, pc_0_o,
               pc_1_o, pred_taken_0_o, pred_taken_1_o, count_o
    );
endinterface

// File: rtl/fetch_buffer.sv
// Dual-push, dual-read show-ahead instruction queue between fetch and decode.
// Occupancy lives in its own counter so full/empty never depend on pointer equality.
module fetch_buffer #(
    parameter int DEPTH = 8
) (
    input logic           clk_i,
    input logic           rst_n_i,
    fetch_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic [DEPTH-1:0] pt_mem;

    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [AW-1:0] head_1;
    logic [AW-1:0] tail_1;
    logic [CW-1:0] count_q;
    logic          fetch_ready;
    logic [1:0]    take_eff;
    logic [1:0]    n_push;
    logic [1:0]    n_pop;

    assign head_1      = head_q + AW'(1);
    assign tail_1      = tail_q + AW'(1);
    assign fetch_ready = (count_q <= CW'(DEPTH - 2));

    // Slot 1 sits on the not-taken path when slot 0 is predicted taken.
    always_comb begin
        n_push = 2'd0;
        if (fetch_ready && bus.push_0_i) begin
            if (!bus.push_1_i || bus.pred_taken_0_i) begin
                n_push = 2'd1;
            end else begin
                n_push = 2'd2;
            end
        end
    end

    always_comb begin
        take_eff = (bus.take_i == 2'd3) ? 2'd2 : bus.take_i;
        n_pop    = take_eff;
        if (count_q < CW'(take_eff)) begin
            n_pop = count_q[1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (bus.flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + AW'(n_pop);
            tail_q  <= tail_q + AW'(n_push);
            count_q <= count_q + CW'(n_push) - CW'(n_pop);
        end
    end

    // Entry storage is never reset; validity comes solely from count_q.
    always_ff @(posedge clk_i) begin
        if (!bus.flush_i && (n_push != 2'd0)) begin
            inst_mem[tail_q] <= bus.inst_0_i;
            pc_mem[tail_q]   <= bus.pc_0_i;
            pt_mem[tail_q]   <= bus.pred_taken_0_i;
            if (n_push == 2'd2) begin
                inst_mem[tail_1] <= bus.inst_1_i;
                pc_mem[tail_1]   <= bus.pc_1_i;
                pt_mem[tail_1]   <= bus.pred_taken_1_i;
            end
        end
    end

    assign bus.fetch_ready_o  = fetch_ready;
    assign bus.valid_0_o      = (count_q >= CW'(1));
    assign bus.valid_1_o      = (count_q >= CW'(2));
    assign bus.inst_0_o       = inst_mem[head_q];
    assign bus.inst_1_o       = inst_mem[head_1];
    assign bus.pc_0_o         = pc_mem[head_q];
    assign bus.pc_1_o         = pc_mem[head_1];
    assign bus.pred_taken_0_o = pt_mem[head_q];
    assign bus.pred_taken_1_o = pt_mem[head_1];
    assign bus.count_o        = count_q;
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed sequences feed an expected-entry queue that a
// negedge monitor compares against the show-ahead outputs and pops as decode consumes.
module tb_fetch_buffer;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_buffer_if #(.DEPTH(DEPTH)) bus ();

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [64:0] exp_q[$];   // {inst, pc, pred_taken}, oldest first
    bit mon_en = 1'b0;
    int mon_sz;
    int mon_np;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic set_idle();
        bus.flush_i        = 1'b0;
        bus.push_0_i       = 1'b0;
        bus.push_1_i       = 1'b0;
        bus.inst_0_i       = '0;
        bus.inst_1_i       = '0;
        bus.pc_0_i         = '0;
        bus.pc_1_i         = '0;
        bus.pred_taken_0_i = 1'b0;
        bus.pred_taken_1_i = 1'b0;
        bus.take_i         = 2'd0;
    endtask

    // Called #1 after a rising edge; drives one cycle and returns #1 after the next edge.
    task automatic cycle(input bit p0, input bit p1,
                         input logic [31:0] i0, input logic [31:0] i1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input bit t0, input bit t1,
                         input logic [1:0] take, input bit flush,
                         output int n_acc);
        int cnt;
        cnt = exp_q.size();
        bus.push_0_i       = p0;
        bus.push_1_i       = p1;
        bus.inst_0_i       = i0;
        bus.inst_1_i       = i1;
        bus.pc_0_i         = a0;
        bus.pc_1_i         = a1;
        bus.pred_taken_0_i = t0;
        bus.pred_taken_1_i = t1;
        bus.take_i         = take;
        bus.flush_i        = flush;
        n_acc = 0;
        if (!flush && p0 && (DEPTH - cnt) >= 2) n_acc = (p1 && !t0) ? 2 : 1;
        @(posedge clk);
        if (n_acc >= 1) exp_q.push_back({i0, a0, t0});
        if (n_acc == 2) exp_q.push_back({i1, a1, t1});
        #1;
        set_idle();
    endtask

    // Monitor: compare presented entries with the scoreboard, then retire what decode takes.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            mon_sz = exp_q.size();
            chk32("mon_count", 32'(bus.count_o), 32'(mon_sz));
            chk1("mon_valid_0", bus.valid_0_o, mon_sz >= 1);
            chk1("mon_valid_1", bus.valid_1_o, mon_sz >= 2);
            chk1("mon_fetch_ready", bus.fetch_ready_o, (DEPTH - mon_sz) >= 2);
            if (mon_sz >= 1 && bus.valid_0_o) begin
                chk32("mon_inst_0", bus.inst_0_o, exp_q[0][64:33]);
                chk32("mon_pc_0", bus.pc_0_o, exp_q[0][32:1]);
                chk1("mon_pt_0", bus.pred_taken_0_o, exp_q[0][0]);
            end
            if (mon_sz >= 2 && bus.valid_1_o) begin
                chk32("mon_inst_1", bus.inst_1_o, exp_q[1][64:33]);
                chk32("mon_pc_1", bus.pc_1_o, exp_q[1][32:1]);
                chk1("mon_pt_1", bus.pred_taken_1_o, exp_q[1][0]);
            end
            if (bus.flush_i) begin
                exp_q.delete();
            end else begin
                mon_np = (bus.take_i == 2'd3) ? 2 : int'(bus.take_i);
                while (mon_np > 0 && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    mon_np--;
                end
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int n;
        int k;
        int out_k;
        int cyc;
        int te;
        int np;
        logic [1:0] tk;

        set_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk32("reset_count", 32'(bus.count_o), 32'd0);
        chk1("reset_valid_0", bus.valid_0_o, 1'b0);
        chk1("reset_valid_1", bus.valid_1_o, 1'b0);
        chk1("reset_fetch_ready", bus.fetch_ready_o, 1'b1);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, n);
            chk32("idle_count", 32'(bus.count_o), 32'd0);
            chk1("idle_valid_0", bus.valid_0_o, 1'b0);
            chk1("idle_fetch_ready", bus.fetch_ready_o, 1'b1);
        end

        // Dual push then dual pop
        cycle(1, 1, 32'h00000013, 32'h00100093, 32'h100, 32'h104, 0, 0, 2'd0, 0, n);
        chk1("dual_valid_0", bus.valid_0_o, 1'b1);
        chk1("dual_valid_1", bus.valid_1_o, 1'b1);
        chk32("dual_pc_0", bus.pc_0_o, 32'h100);
        chk32("dual_pc_1", bus.pc_1_o, 32'h104);
        chk32("dual_inst_1", bus.inst_1_o, 32'h00100093);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 0, n);
        chk32("dual_pop_count", 32'(bus.count_o), 32'd0);

        // Predicted-taken slot 0 drops slot 1
        cycle(1, 1, 32'h0000_0063, 32'h0020_0113, 32'h200, 32'h204, 1, 0, 2'd0, 0, n);
        chk32("pt_count", 32'(bus.count_o), 32'd1);
        chk1("pt_valid_1", bus.valid_1_o, 1'b0);
        chk1("pt_taken_0", bus.pred_taken_0_o, 1'b1);
        chk32("pt_pc_0", bus.pc_0_o, 32'h200);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0, n);
        chk32("pt_drain_count", 32'(bus.count_o), 32'd0);

        // Fill to DEPTH with pairs and no pops
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 32'h1000_0000 + 32'(2 * i), 32'h1000_0001 + 32'(2 * i),
                  32'h300 + 32'(8 * i), 32'h304 + 32'(8 * i), 0, 0, 2'd0, 0, n);
            chk32("fill_count", 32'(bus.count_o), 32'(2 * (i + 1)));
            chk1("fill_ready", bus.fetch_ready_o, i < 3);
        end
        cycle(1, 1, 32'hdead_beef, 32'hdead_beef, 32'h999, 32'h99d, 0, 0, 2'd0, 0, n);
        chk32("full_ignore_count", 32'(bus.count_o), 32'd8);
        chk32("full_ignore_pc_0", bus.pc_0_o, 32'h300);
        chk32("full_ignore_pc_1", bus.pc_1_o, 32'h304);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0, n);
        chk32("take1_count", 32'(bus.count_o), 32'd7);
        chk1("take1_ready", bus.fetch_ready_o, 1'b0);
        chk32("take1_pc_0", bus.pc_0_o, 32'h304);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0, n);
        chk32("take1b_count", 32'(bus.count_o), 32'd6);
        chk1("take1b_ready", bus.fetch_ready_o, 1'b1);
        chk32("take1b_pc_0", bus.pc_0_o, 32'h308);

        // count 7 with a dual pop in the same cycle: the push is still refused
        cycle(1, 0, 32'h2222_0000, 0, 32'h320, 0, 0, 0, 2'd0, 0, n);
        chk32("seven_count", 32'(bus.count_o), 32'd7);
        chk1("seven_ready", bus.fetch_ready_o, 1'b0);
        cycle(1, 1, 32'h3333_0000, 32'h3333_0001, 32'h500, 32'h504, 0, 0, 2'd2, 0, n);
        chk32("boundary_count", 32'(bus.count_o), 32'd5);
        chk32("boundary_pc_0", bus.pc_0_o, 32'h310);
        chk1("boundary_ready", bus.fetch_ready_o, 1'b1);

        // take of 3 acts as 2; take beyond occupancy is clamped
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 0, n);
        chk32("take3_count", 32'(bus.count_o), 32'd3);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 0, n);
        chk32("take2_count", 32'(bus.count_o), 32'd1);
        chk32("take2_pc_0", bus.pc_0_o, 32'h320);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 0, n);
        chk32("clamp_count", 32'(bus.count_o), 32'd0);

        // Stream 40 sequential PCs with random take across pointer wrap
        k = 0;
        out_k = 0;
        cyc = 0;
        while ((k < 40 || exp_q.size() > 0) && cyc < 400) begin
            tk = 2'($urandom_range(0, 3));
            te = (tk == 2'd3) ? 2 : int'(tk);
            np = (te < exp_q.size()) ? te : exp_q.size();
            if (bus.valid_0_o) chk32("stream_pc_seq", bus.pc_0_o, 32'h1000 + 32'(4 * out_k));
            cycle(k < 40, k + 1 < 40, 32'hc000_0000 + 32'(k), 32'hc000_0001 + 32'(k),
                  32'h1000 + 32'(4 * k), 32'h1004 + 32'(4 * k), 0, 0, tk, 0, n);
            k += n;
            out_k += np;
            cyc++;
        end
        chk32("stream_pushed", 32'(k), 32'd40);
        chk32("stream_consumed", 32'(out_k), 32'd40);
        chk32("stream_end_count", 32'(bus.count_o), 32'd0);

        // Flush mid-stream beats a same-cycle push and pop
        cycle(1, 1, 32'h4000_0000, 32'h4000_0001, 32'h2000, 32'h2004, 0, 0, 2'd0, 0, n);
        cycle(1, 1, 32'h4000_0002, 32'h4000_0003, 32'h2008, 32'h200c, 0, 0, 2'd0, 0, n);
        cycle(1, 0, 32'h4000_0004, 0, 32'h2010, 0, 0, 0, 2'd0, 0, n);
        chk32("preflush_count", 32'(bus.count_o), 32'd5);
        cycle(1, 0, 32'h5555_5555, 0, 32'h3000, 0, 0, 0, 2'd2, 1, n);
        chk32("flush_count", 32'(bus.count_o), 32'd0);
        chk1("flush_valid_0", bus.valid_0_o, 1'b0);
        chk1("flush_valid_1", bus.valid_1_o, 1'b0);
        chk1("flush_ready", bus.fetch_ready_o, 1'b1);
        cycle(1, 0, 32'h6666_0000, 0, 32'h4000, 0, 0, 0, 2'd0, 0, n);
        chk1("postflush_valid_0", bus.valid_0_o, 1'b1);
        chk32("postflush_pc_0", bus.pc_0_o, 32'h4000);
        chk32("postflush_count", 32'(bus.count_o), 32'd1);

        // Asynchronous reset mid-operation
        cycle(1, 1, 32'h7777_0000, 32'h7777_0001, 32'h5000, 32'h5004, 0, 0, 2'd0, 0, n);
        chk32("prereset_count", 32'(bus.count_o), 32'd3);
        rst_n = 1'b0;
        #1;
        chk32("midreset_count", 32'(bus.count_o), 32'd0);
        chk1("midreset_valid_0", bus.valid_0_o, 1'b0);
        chk1("midreset_ready", bus.fetch_ready_o, 1'b1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, 0, 32'h8888_0000, 0, 32'h6000, 0, 0, 0, 2'd0, 0, n);
        chk32("postreset_pc_0", bus.pc_0_o, 32'h6000);
        chk32("postreset_count", 32'(bus.count_o), 32'd1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0, n);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
